// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared pipeline constants for the MEM-stage data cache
package data_cache_pkg;

  localparam int WORD_W = 32;

  // Miss-path FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_RD_MISS = 2'd2;
  localparam logic [1:0] ST_WR_THRU = 2'd3;

  // Wide enough for SRAM_DELAY up to 7
  localparam int DLY_W = 3;

endpackage

// File: rtl/cache_array.sv
// rtl/cache_array.sv - direct-mapped line storage: async read, sync write, async valid clear
module cache_array
  import data_cache_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int IDX_W = 6,
  parameter int TAG_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  idx,
  output logic              line_valid,
  output logic [TAG_W-1:0]  line_tag,
  output logic [WORD_W-1:0] line_data,
  input  logic              we,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] data_mem [SETS];
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]   valid;

  // Data and tags need no reset; a cleared valid bit masks them
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[idx] <= wdata;
      tag_mem[idx]  <= wtag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
    end
  end

  assign line_valid = valid[idx];
  assign line_tag   = tag_mem[idx];
  assign line_data  = data_mem[idx];

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - one-word-line direct-mapped write-through data cache for the MEM stage
module data_cache
  import data_cache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int SRAM_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       address,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [31:0]       sram_address,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((SRAM_DELAY > 0) ? SRAM_DELAY - 1 : 0);

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              line_valid;
  logic [TAG_W-1:0]  line_tag;
  logic [WORD_W-1:0] line_data;
  logic              line_we;
  logic [WORD_W-1:0] line_wdata;
  logic              hit;

  logic [1:0]        state, state_n;
  logic [DLY_W-1:0]  cnt, cnt_n;

  assign idx = address[IDX_W+1:2];
  assign tag = address[31:IDX_W+2];
  assign hit = line_valid && (line_tag == tag);

  // The MEM stage is frozen while ready=0, so address/wdata stay put for the whole request
  assign sram_address = address;
  assign sram_wdata   = wdata;
  assign line_wdata   = (state == ST_RD_MISS) ? sram_rdata : wdata;

  cache_array #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .line_valid (line_valid),
    .line_tag   (line_tag),
    .line_data  (line_data),
    .we         (line_we),
    .wtag       (tag),
    .wdata      (line_wdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ready     = 1'b1;
    rdata     = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    line_we   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (MEM_W_EN) begin
          ready   = 1'b0;
          state_n = ST_WR_THRU;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata = line_data;
          end else begin
            ready = 1'b0;
            if (SRAM_DELAY > 0) begin
              state_n = ST_WAIT;
              cnt_n   = DLY_LAST;
            end else begin
              state_n = ST_RD_MISS;
            end
          end
        end
      end
      ST_WAIT: begin
        ready = 1'b0;
        if (cnt == '0) begin
          state_n = ST_RD_MISS;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      ST_RD_MISS: begin
        sram_r_en = 1'b1;
        if (sram_ready) begin
          rdata   = sram_rdata;
          line_we = 1'b1;
          state_n = ST_IDLE;
        end else begin
          ready = 1'b0;
        end
      end
      ST_WR_THRU: begin
        sram_w_en = 1'b1;
        if (sram_ready) begin
          // No-write-allocate: only a line already holding this word is refreshed
          line_we = hit;
          state_n = ST_IDLE;
        end else begin
          ready = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Outputs go quiet immediately while reset is held, not at the next edge
    if (!rst) begin
      ready     = 1'b1;
      rdata     = '0;
      sram_r_en = 1'b0;
      sram_w_en = 1'b0;
      line_we   = 1'b0;
    end
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have parameter SETS, default 64, meaning the number of one-word direct-mapped lines (power of two, 2..1024).
REQ-002 SHALL have parameter SRAM_DELAY, default 0, meaning extra miss-path idle cycles (0..7) inserted before SRAM_CTRL is asserted; used for bench stress.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port MEM_R_EN  input  1  load request from MEM stage.
REQ-006 SHALL have port MEM_W_EN  input  1  store request from MEM stage.
REQ-007 SHALL have port address  input  32  byte address from MEM stage; bits [1:0] ignored.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  load data, valid while ready=1 and MEM_R_EN=1.
REQ-010 SHALL have port ready  output  1  request complete; 0 freezes the pipeline.
REQ-011 SHALL have ports sram_r_en, sram_w_en  output  1  read/write request to SRAM_CTRL.
REQ-012 SHALL have ports sram_address  output  32, sram_wdata  output  32, sram_rdata  input  32, sram_ready  input  1, forming the SRAM_CTRL request/response.

Function
REQ-013 SHALL index with address[log2(SETS)+1:2]; tag = remaining upper bits; one valid bit per line.
REQ-014 SHALL implement states IDLE, WAIT, RD_MISS, WR_THRU.
REQ-015 SHALL, with no request, hold IDLE and drive ready=1, rdata=0, sram_r_en=0, sram_w_en=0.
REQ-016 SHALL, on a read hit in IDLE, drive ready=1 and rdata=line data combinationally in the same cycle (zero-latency); no SRAM access.
REQ-017 SHALL, on a read miss, drive ready=0 and go to WAIT (if SRAM_DELAY>0, counting SRAM_DELAY cycles) then RD_MISS; with SRAM_DELAY=0 go directly to RD_MISS.
REQ-018 SHALL, in RD_MISS, hold sram_r_en=1 and sram_address=address until sram_ready=1; in that cycle drive rdata=sram_rdata and ready=1, write data, tag and valid=1 into the line, and return to IDLE.
REQ-019 SHALL treat every store as write-through, no-write-allocate: go to WR_THRU, hold sram_w_en=1, sram_address=address, sram_wdata=wdata until sram_ready=1, then drive ready=1 and return to IDLE.
REQ-020 SHALL, on a store hit, update line data with wdata on the completing edge; a store miss SHALL leave the array untouched.
REQ-021 SHALL give MEM_W_EN priority when MEM_R_EN and MEM_W_EN are both 1 (illegal encoding; no read performed).
REQ-022 SHALL sample address/wdata continuously from the frozen MEM stage; sram outputs track the inputs.
REQ-023 SHALL never assert sram_r_en and sram_w_en together, and SHALL deassert both in IDLE.
REQ-024 SHALL allow a back-to-back request in the cycle after completion (IDLE re-evaluates immediately).

Reset
REQ-025 SHALL, on rst=0 at any time (including mid-miss or mid-store), asynchronously clear all valid bits, force state IDLE, clear the WAIT counter, and drive ready=1, sram_r_en=0, sram_w_en=0, rdata=0.
REQ-026 SHALL not require data/tag arrays to be reset; only valid bits.

Structure
REQ-027 SHALL place state encoding and the SRAM_DELAY counter width in a shared package/header alongside the other MIPS pipeline constants.
REQ-028 SHALL use one sub-module, cache_array (data+tag+valid storage, async read, sync write, async valid clear).

Verification
REQ-029 Read 0x00000404 after reset, SRAM returns 0xDEADBEEF with sram_ready after 3 cycles -> ready=0 for 3 cycles, ready=1 with rdata=0xDEADBEEF on 4th; re-read -> ready=1 same cycle, no sram_r_en.
REQ-030 Store 0x12345678 to 0x00000404 after it is cached -> sram_w_en held until sram_ready; subsequent read hits with 0x12345678.
REQ-031 Store to uncached 0x00000808, then read 0x00000808 -> read misses (no allocate), sram_r_en asserted.
REQ-032 Conflict: read 0x00000004 then 0x00000104 (SETS=64, same index) -> both miss; re-read 0x00000004 misses again.
REQ-033 rst=0 asserted mid RD_MISS -> sram_r_en drops asynchronously, ready=1; prior hit address misses after reset release.
REQ-034 MEM_R_EN=MEM_W_EN=1 -> only sram_w_en asserted; SRAM_DELAY=2 read miss -> exactly 2 WAIT cycles before sram_r_en rises.
